// File: rtl/pw_pkg.sv
// pw_pkg: shared state encodings, byte width and length-field width helper for the pattern matcher
package pw_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FIRED = 2'd2} state_e;
  function automatic int len_w(input int pb);
    return $clog2(pb + 1);
  endfunction
endpackage

// File: rtl/pw_match_window.sv
// pw_match_window: sliding byte window, fill counter and per-byte masked compare
//  clk/rst_n   clock, async active-low reset
//  clear_i     zero fill (arm cycle)
//  shift_i     accept data_i into window[0]
//  fall_i      packet ended; zero fill after any shift
//  pat_i/msk_i snapshotted pattern and mask, byte i = i bytes before newest
//  match_vec_o per-byte compare result against the post-shift window
//  fill_nxt_o  fill including this cycle's byte, before the packet-end clear
module pw_match_window
  import pw_pkg::*;
#(
  parameter int PB = 8,
  parameter int LW = len_w(PB)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 shift_i,
  input  logic                 fall_i,
  input  logic [BYTE_W-1:0]    data_i,
  input  logic [PB*BYTE_W-1:0] pat_i,
  input  logic [PB*BYTE_W-1:0] msk_i,
  output logic [PB-1:0]        match_vec_o,
  output logic [LW-1:0]        fill_nxt_o
);
  logic [PB*BYTE_W-1:0] win_q, win_d;
  logic [LW-1:0] fill_q, fill_d, fill_inc;
  always_comb begin
    win_d = shift_i ? {win_q[PB*BYTE_W-BYTE_W-1:0], data_i} : win_q;
    fill_inc = (fill_q == LW'(PB)) ? fill_q : fill_q + LW'(1);
    fill_nxt_o = shift_i ? fill_inc : fill_q;
    fill_d = (clear_i || fall_i) ? '0 : fill_nxt_o;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      fill_q <= '0;
    end else begin
      win_q <= win_d;
      fill_q <= fill_d;
    end
  end
  for (genvar g = 0; g < PB; g++) begin : g_cmp
    assign match_vec_o[g] =
      ((win_d[g*BYTE_W +: BYTE_W] ^ pat_i[g*BYTE_W +: BYTE_W]) & msk_i[g*BYTE_W +: BYTE_W]) == '0;
  end
endmodule

// File: rtl/pw_pattern_match.sv
// pw_pattern_match: masked byte-pattern matcher on the sniffed USB stream with arm/one-shot control
//  usb_clk/reset_n  clock, async-assert / sync-release active-low reset
//  I_arm/I_disarm   arm (snapshot pattern, mask, length, mode) / disarm; disarm wins
//  I_continuous     1 = stay armed after a match
//  I_pattern/I_mask byte i = i bytes before newest; mask bit set = compare
//  I_bytes          pattern length, 0 never matches, above PATTERN_BYTES clamps
//  I_data/I_data_valid/I_rxactive  sniffed byte stream and packet envelope
//  O_match          one-cycle pulse the cycle after the completing byte
//  O_armed          state == ARMED
//  O_match_count    saturating matches since last arm
module pw_pattern_match
  import pw_pkg::*;
#(
  parameter int PATTERN_BYTES = 8,
  parameter int CNT_W = 8
) (
  input  logic                            usb_clk,
  input  logic                            reset_n,
  input  logic                            I_arm,
  input  logic                            I_disarm,
  input  logic                            I_continuous,
  input  logic [PATTERN_BYTES*BYTE_W-1:0] I_pattern,
  input  logic [PATTERN_BYTES*BYTE_W-1:0] I_mask,
  input  logic [len_w(PATTERN_BYTES)-1:0] I_bytes,
  input  logic [BYTE_W-1:0]               I_data,
  input  logic                            I_data_valid,
  input  logic                            I_rxactive,
  output logic                            O_match,
  output logic                            O_armed,
  output logic [CNT_W-1:0]                O_match_count
);
  localparam int LW = len_w(PATTERN_BYTES);
  logic [1:0] rst_sync_q;
  logic rst_n;
  state_e state_q, state_d;
  logic [PATTERN_BYTES*BYTE_W-1:0] pat_q, msk_q;
  logic [LW-1:0] len_q, len_c, fill_nxt;
  logic cont_q, rx_q, match_q, armed_q, shift, hit;
  logic [CNT_W-1:0] cnt_q;
  logic [PATTERN_BYTES-1:0] match_vec;
  // release is resynchronised so every flop leaves reset on the same edge
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];
  pw_match_window #(.PB(PATTERN_BYTES), .LW(LW)) u_win (
    .clk        (usb_clk),
    .rst_n      (rst_n),
    .clear_i    (I_arm && !I_disarm),
    .shift_i    (shift),
    .fall_i     (rx_q && !I_rxactive),
    .data_i     (I_data),
    .pat_i      (pat_q),
    .msk_i      (msk_q),
    .match_vec_o(match_vec),
    .fill_nxt_o (fill_nxt)
  );
  // lanes at or beyond the pattern length are forced true by the shifted-in ones
  always_comb begin
    shift = (state_q == ARMED) && I_data_valid && !I_arm;
    len_c = (I_bytes > LW'(PATTERN_BYTES)) ? LW'(PATTERN_BYTES) : I_bytes;
    hit = shift && !I_disarm && (len_q != '0) && (fill_nxt >= len_q) &&
          (&(match_vec | ({PATTERN_BYTES{1'b1}} << len_q)));
    state_d = I_disarm ? IDLE : I_arm ? ARMED : (hit && !cont_q) ? FIRED : state_q;
  end
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q <= '0;
      msk_q <= '0;
      len_q <= '0;
      cont_q <= 1'b0;
      rx_q <= 1'b0;
      match_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= state_d == ARMED;
      rx_q <= I_rxactive;
      match_q <= hit;
      if (I_arm && !I_disarm) begin
        pat_q <= I_pattern;
        msk_q <= I_mask;
        len_q <= len_c;
        cont_q <= I_continuous;
        cnt_q <= '0;
      end else if (hit) begin
        cnt_q <= cnt_q + CNT_W'(~&cnt_q);
      end
    end
  end
  assign O_match = match_q;
  assign O_armed = armed_q;
  assign O_match_count = cnt_q;
endmodule

// File: tb/tb_pw_pattern_match.sv
// tb_pw_pattern_match: directed self-checking bench for pw_pattern_match
module tb_pw_pattern_match;
  logic usb_clk = 0, reset_n = 0;
  logic I_arm = 0, I_disarm = 0, I_continuous = 0;
  logic [63:0] I_pattern = '0, I_mask = '0;
  logic [3:0] I_bytes = '0;
  logic [7:0] I_data = '0;
  logic I_data_valid = 0, I_rxactive = 1;
  logic O_match, O_armed;
  logic [7:0] O_match_count;
  int n_cmp = 0, n_err = 0;
  pw_pattern_match #(.PATTERN_BYTES(8), .CNT_W(8)) dut (
    .usb_clk(usb_clk), .reset_n(reset_n), .I_arm(I_arm), .I_disarm(I_disarm),
    .I_continuous(I_continuous), .I_pattern(I_pattern), .I_mask(I_mask), .I_bytes(I_bytes),
    .I_data(I_data), .I_data_valid(I_data_valid), .I_rxactive(I_rxactive),
    .O_match(O_match), .O_armed(O_armed), .O_match_count(O_match_count)
  );
  always #5 usb_clk = ~usb_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask
  task automatic arm(input logic cont, input logic [63:0] pat, input logic [63:0] msk, input logic [3:0] len);
    I_continuous = cont; I_pattern = pat; I_mask = msk; I_bytes = len; I_arm = 1;
    tick();
    I_arm = 0;
  endtask
  task automatic send(input logic [7:0] b);
    I_data = b; I_data_valid = 1;
    tick();
    I_data_valid = 0;
  endtask
  initial begin
    #2;
    chk("rst_match", O_match, 0);
    chk("rst_armed", O_armed, 0);
    chk("rst_count", O_match_count, 0);
    reset_n = 1;
    repeat (3) tick();
    // 1: exact two-byte pattern, one-shot
    arm(0, 64'h1234, 64'hFFFF, 2);
    chk("t1_armed", O_armed, 1);
    send(8'h12); chk("t1_no_early", O_match, 0);
    send(8'h34); chk("t1_match", O_match, 1);
    chk("t1_count", O_match_count, 1);
    chk("t1_fired", O_armed, 0);
    tick(); chk("t1_pulse_1cyc", O_match, 0);
    send(8'h12); send(8'h34); chk("t1_fired_ignores", O_match, 0);
    chk("t1_count_hold", O_match_count, 1);
    // 2: masked nibble compare on the older byte
    arm(0, 64'h0200, 64'h0F00, 2);
    chk("t2_rearm_from_fired", O_armed, 1);
    chk("t2_count_clear", O_match_count, 0);
    send(8'hA2); send(8'hFF); chk("t2_masked_match", O_match, 1);
    arm(0, 64'h0200, 64'h0F00, 2);
    send(8'hA3); send(8'hFF); chk("t2_masked_miss", O_match, 0);
    // 3: continuous overlap and saturation
    arm(1, 64'hAAAA, 64'hFFFF, 2);
    send(8'hAA); chk("t3_first", O_match, 0);
    send(8'hAA); chk("t3_second", O_match, 1);
    send(8'hAA); chk("t3_third", O_match, 1);
    chk("t3_count2", O_match_count, 2);
    chk("t3_still_armed", O_armed, 1);
    for (int i = 0; i < 300; i++) send(8'hAA);
    chk("t3_sat", O_match_count, 255);
    chk("t3_sat_pulse", O_match, 1);
    // 4: packet boundary clears fill
    arm(1, 64'h1234, 64'hFFFF, 2);
    send(8'h12);
    I_rxactive = 0; tick();
    I_rxactive = 1; tick();
    send(8'h34); chk("t4_no_span", O_match, 0);
    send(8'h12); send(8'h34); chk("t4_in_packet", O_match, 1);
    // 5: zero length, clamped length, arm+disarm collision
    arm(1, 64'hAAAA, 64'hFFFF, 0);
    send(8'hAA); send(8'hAA); send(8'hAA); chk("t5_len0", O_match, 0);
    chk("t5_len0_count", O_match_count, 0);
    arm(1, 64'h0807060504030201, '1, 15);
    for (int i = 8; i >= 2; i--) send(8'(i));
    chk("t5_len8_short", O_match, 0);
    send(8'h01); chk("t5_len8_match", O_match, 1);
    arm(1, 64'h0807060504030201, '1, 15);
    send(8'hFF);
    for (int i = 7; i >= 1; i--) send(8'(i));
    chk("t5_clamp_is_8", O_match, 0);
    I_disarm = 1; tick(); I_disarm = 0;
    chk("t5_disarm", O_armed, 0);
    I_arm = 1; I_disarm = 1; tick(); I_arm = 0; I_disarm = 0;
    chk("t5_disarm_wins", O_armed, 0);
    // 6: async reset mid-packet
    arm(1, 64'h1234, 64'hFFFF, 2);
    send(8'h12); send(8'h34);
    chk("t6_pre_count", O_match_count, 1);
    I_rxactive = 0; tick(); I_rxactive = 1;
    send(8'h12);
    reset_n = 0; #1;
    chk("t6_async_armed", O_armed, 0);
    chk("t6_async_count", O_match_count, 0);
    chk("t6_async_match", O_match, 0);
    #3 reset_n = 1;
    repeat (3) tick();
    send(8'h34); chk("t6_no_pulse", O_match, 0);
    chk("t6_idle", O_armed, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
